// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_pkg - shared state type, default width and parity helper           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package regfile_pkg;

  localparam int RF_XLEN_DEFAULT = 32;
  // Parity helper operand width; callers zero-extend, which leaves parity unchanged.
  localparam int RF_PAR_W = 128;

  typedef enum logic [0:0] {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

  function automatic logic rf_parity(input logic [RF_PAR_W-1:0] data);
    return ^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rf_read_port - zero-register, write-bypass and busy masking for one port.  |
// | Optional REGFILE_PARITY_EN adds a parity-error output. Rev 1.0             |
// +----------------------------------------------------------------------------+
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int XLEN     = RF_XLEN_DEFAULT,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
)(
  input  logic            run,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] entry_data,
  input  logic            entry_busy,
`ifdef REGFILE_PARITY_EN
  input  logic            entry_par,
  output logic            par_err,
`endif
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  logic is_zero;
  logic is_bypass;

  assign is_zero   = (ZERO_REG != 0) && (addr == '0);
  assign is_bypass = wr_en && (wr_addr == addr);

  always_comb begin
    data = '0;
    busy = 1'b0;
    if (run && !is_zero) begin
      data = is_bypass ? wr_data : entry_data;
      busy = entry_busy && !is_bypass;
    end
  end

`ifdef REGFILE_PARITY_EN
  assign par_err = run && !is_zero && !is_bypass &&
                   (rf_parity(RF_PAR_W'(entry_data)) != entry_par);
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_scoreboard - multi-read register file with scrub-on-reset and      |
// | scoreboard busy bits. Optional macro REGFILE_PARITY_EN. Rev 1.0            |
// +----------------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN     = RF_XLEN_DEFAULT,
  parameter  int DEPTH    = 32,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   resv_en,
  input  logic [AW-1:0]          resv_addr,
  output logic                   resv_ack,
`ifdef REGFILE_PARITY_EN
  output logic [NUM_RD-1:0]      rd_par_err,
`endif
  output logic                   ready
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("regfile_scoreboard: DEPTH must be a power of two and >= 2");
  end

  rf_state_t        state;
  logic [AW-1:0]    scrub_cnt;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [XLEN-1:0]  mem [DEPTH];
  logic             run;
  logic             wr_ok;

  assign run      = (state == RF_RUN);
  assign ready    = run;
  assign wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign resv_ack = run && resv_en &&
                    (!busy[resv_addr] || (wr_en && (wr_addr == resv_addr)));

  // Reservation is applied after the writeback clear so it wins on a collision.
  always_comb begin
    busy_nxt = busy;
    if (wr_en)    busy_nxt[wr_addr]   = 1'b0;
    if (resv_ack) busy_nxt[resv_addr] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0]    = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RF_INIT;
      scrub_cnt <= '0;
      busy      <= '0;
    end else if (state == RF_INIT) begin
      scrub_cnt <= scrub_cnt + 1'b1;
      if (scrub_cnt == AW'(DEPTH - 1)) state <= RF_RUN;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Storage carries no reset so it can map onto RAM; the scrub clears it instead.
  always_ff @(posedge clk) begin
    if (!run)       mem[scrub_cnt] <= '0;
    else if (wr_ok) mem[wr_addr]   <= wr_data;
  end

`ifdef REGFILE_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!run)       par_mem[scrub_cnt] <= rf_parity('0);
    else if (wr_ok) par_mem[wr_addr]   <= rf_parity(RF_PAR_W'(wr_data));
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
    logic [AW-1:0] addr_i;
    assign addr_i = rd_addr[i*AW +: AW];

    rf_read_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .run        (run),
      .addr       (addr_i),
      .entry_data (mem[addr_i]),
      .entry_busy (busy[addr_i]),
`ifdef REGFILE_PARITY_EN
      .entry_par  (par_mem[addr_i]),
      .par_err    (rd_par_err[i]),
`endif
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .data       (rd_data[i*XLEN +: XLEN]),
      .busy       (rd_busy[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_scoreboard - table vectors, corner sequences and random traffic |
// | against a behavioural register-file model. Rev 1.0                         |
// +----------------------------------------------------------------------------+
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_RD*AW-1:0]   rd_addr = '0;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   wr_en = 1'b0;
  logic [AW-1:0]          wr_addr = '0;
  logic [XLEN-1:0]        wr_data = '0;
  logic                   resv_en = 1'b0;
  logic [AW-1:0]          resv_addr = '0;
  logic                   resv_ack;
  logic                   ready;
`ifdef REGFILE_PARITY_EN
  logic [NUM_RD-1:0]      rd_par_err;
`endif

  regfile_scoreboard #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .resv_en    (resv_en),
    .resv_addr  (resv_addr),
    .resv_ack   (resv_ack),
`ifdef REGFILE_PARITY_EN
    .rd_par_err (rd_par_err),
`endif
    .ready      (ready)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Architectural view of the register file: contents and outstanding reservations.
  logic [XLEN-1:0] m_mem  [DEPTH];
  bit              m_busy [DEPTH];

  typedef struct {
    bit              we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    bit              re;
    logic [AW-1:0]   ra;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] d0;
    logic [XLEN-1:0] d1;
    bit              b0;
    bit              b1;
    bit              ack;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                       input bit re, input logic [AW-1:0] ra,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    resv_en = re; resv_addr = ra;
    rd_addr = {a1, a0};
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    return (a != 0) && m_busy[a] && !(wr_en && wr_addr == a);
  endfunction

  function automatic bit exp_ack();
    return resv_en && (!m_busy[resv_addr] || (wr_en && wr_addr == resv_addr));
  endfunction

  // Apply the upcoming clock edge to the model using the currently driven inputs.
  task automatic model_step();
    bit ack;
    ack = exp_ack();
    if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
    if (wr_en) m_busy[wr_addr] = 1'b0;
    if (ack && resv_addr != 0) m_busy[resv_addr] = 1'b1;
  endtask

  task automatic check_model(input string tag);
    logic [AW-1:0] a0, a1;
    a0 = rd_addr[AW-1:0];
    a1 = rd_addr[2*AW-1:AW];
    check({tag, "_d0"},  64'(rd_data[XLEN-1:0]),      64'(exp_data(a0)));
    check({tag, "_d1"},  64'(rd_data[2*XLEN-1:XLEN]), 64'(exp_data(a1)));
    check({tag, "_bsy"}, 64'(rd_busy), 64'({exp_busy(a1), exp_busy(a0)}));
    check({tag, "_ack"}, 64'(resv_ack), 64'(exp_ack()));
`ifdef REGFILE_PARITY_EN
    check({tag, "_par"}, 64'(rd_par_err), 64'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    vecs[1]  = '{0, 0, 32'h0,        0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0};
    vecs[2]  = '{1, 0, 32'h1234,     0, 0, 0, 5, 32'h0,        32'hDEADBEEF, 0, 0, 0};
    vecs[3]  = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0};
    vecs[4]  = '{0, 0, 32'h0,        1, 7, 7, 7, 32'h0,        32'h0,        0, 0, 1};
    vecs[5]  = '{0, 0, 32'h0,        1, 7, 7, 7, 32'h0,        32'h0,        1, 1, 0};
    vecs[6]  = '{1, 7, 32'h77,       1, 7, 7, 3, 32'h77,       32'h0,        0, 0, 1};
    vecs[7]  = '{0, 0, 32'h0,        0, 0, 7, 7, 32'h77,       32'h77,       1, 1, 0};
    vecs[8]  = '{0, 0, 32'h0,        1, 9, 7, 9, 32'h77,       32'h0,        1, 0, 1};
    vecs[9]  = '{1, 9, 32'h99,       0, 0, 7, 9, 32'h77,       32'h99,       1, 0, 0};
    vecs[10] = '{0, 0, 32'h0,        0, 0, 9, 9, 32'h99,       32'h99,       0, 0, 0};
    vecs[11] = '{0, 0, 32'h0,        1, 0, 0, 9, 32'h0,        32'h99,       0, 0, 1};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 0, 7, 32'h0,        32'h77,       0, 1, 0};
    vecs[13] = '{1, 7, 32'h78,       0, 0, 7, 7, 32'h78,       32'h78,       0, 0, 0};
    vecs[14] = '{0, 0, 32'h0,        0, 0, 7, 0, 32'h78,       32'h0,        0, 0, 0};

    // Reset held: outputs quiet even with requests pending.
    drive(1, 5, 32'h55, 1, 3, 5, 3);
    #12;
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_ack",   64'(resv_ack), 64'(0));
    check("rst_data",  64'(rd_data), 64'(0));
    check("rst_busy",  64'(rd_busy), 64'(0));

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("init_ready_%0d", k), 64'(ready), 64'(k == DEPTH));
      if (k < DEPTH - 1) begin
        drive(1, 5'(k), $urandom, 1, 5'(k), 5'(k), 5);
        #1;
        check($sformatf("init_ack_%0d", k), 64'(resv_ack), 64'(0));
        check($sformatf("init_data_%0d", k), 64'(rd_data), 64'(0));
      end else if (k == DEPTH - 1) begin
        drive(0, 0, 0, 0, 0, 0, 0);
      end
    end

    model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {5'(DEPTH - 1 - a), 5'(a)};
      #1;
      check($sformatf("scrub_data_%0d", a), 64'(rd_data), 64'(0));
      check($sformatf("scrub_busy_%0d", a), 64'(rd_busy), 64'(0));
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].a0, vecs[i].a1);
      #2;
      check($sformatf("vec%0d_d0", i),  64'(rd_data[XLEN-1:0]),      64'(vecs[i].d0));
      check($sformatf("vec%0d_d1", i),  64'(rd_data[2*XLEN-1:XLEN]), 64'(vecs[i].d1));
      check($sformatf("vec%0d_b0", i),  64'(rd_busy[0]), 64'(vecs[i].b0));
      check($sformatf("vec%0d_b1", i),  64'(rd_busy[1]), 64'(vecs[i].b1));
      check($sformatf("vec%0d_ack", i), 64'(resv_ack),   64'(vecs[i].ack));
      model_step();
      @(posedge clk);
      #1;
    end

    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      #2;
      check_model($sformatf("rnd%0d", n));
      model_step();
      @(posedge clk);
      #1;
    end

    // Reset in the middle of RUN with x3 holding data and reserved.
    drive(1, 3, 32'hA5A5A5A5, 0, 0, 3, 3);
    #2; model_step(); @(posedge clk); #1;
    drive(0, 0, 0, 1, 3, 3, 3);
    #2; model_step(); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 3, 3);
    #2;
    check("pre_rst_data", 64'(rd_data[XLEN-1:0]), 64'(32'hA5A5A5A5));
    check("pre_rst_busy", 64'(rd_busy), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(ready), 64'(0));
    check("midrst_data",  64'(rd_data), 64'(0));
    check("midrst_busy",  64'(rd_busy), 64'(0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    while (!ready && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("rescrub_cycles", 64'(cyc), 64'(DEPTH));
    check("rescrub_x3_data", 64'(rd_data), 64'(0));
    check("rescrub_x3_busy", 64'(rd_busy), 64'(0));
    drive(0, 0, 0, 1, 3, 3, 0);
    #2;
    check_model("post_rescrub");
    model_step();
    @(posedge clk);
    #1;

`ifdef REGFILE_PARITY_EN
    drive(1, 4, 32'h10, 0, 0, 4, 0);
    #2; model_step(); @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 4, 0);
    dut.mem[4] = dut.mem[4] ^ 32'h1;
    #2;
    check("par_flip_err", 64'(rd_par_err[0]), 64'(1));
    drive(1, 4, 32'h20, 0, 0, 4, 0);
    #2;
    check("par_bypass_err", 64'(rd_par_err[0]), 64'(0));
    @(posedge clk); #1;
`endif

    drive(0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
